// File: rtl/ad9833_spi_burst_wr.sv
// ad9833_spi_burst_wr: burst serial writer for AD9833-class SCLK/FSYNC/SDATA ports, one FSYNC frame per word.
// Optional AD9833_SHADOW_EN adds last_word, a copy of the most recently sent word.
module ad9833_spi_burst_wr #(
  parameter int DATA_W      = 16,
  parameter int MAX_WORDS   = 4,
  parameter int CLK_DIV     = 2,
  parameter int FSYNC_SETUP = 1,
  parameter int FSYNC_GAP   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(MAX_WORDS+1)-1:0]   num_words,
  input  logic [DATA_W*MAX_WORDS-1:0]      wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             word_done,
  output logic                             sclk,
  output logic                             fsync,
  output logic                             sdata
`ifdef AD9833_SHADOW_EN
  , output logic [DATA_W-1:0]              last_word
`endif
);
  localparam int NW = $clog2(MAX_WORDS+1);
  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(CLK_DIV+1);
  localparam int TW = $clog2((FSYNC_SETUP > FSYNC_GAP ? FSYNC_SETUP : FSYNC_GAP) + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, FIN} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, wd_q, wd_d;
  logic sclk_q, sclk_d, fsync_q, fsync_d, sdata_q, sdata_d;
  logic [DATA_W*MAX_WORDS-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_rot;
  logic [NW-1:0] left_q, left_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic bad_cnt;
`ifdef AD9833_SHADOW_EN
  logic [DATA_W-1:0] lw_q, lw_d;
  assign last_word = lw_q;
`endif
  assign bad_cnt = (num_words == '0) || (num_words > NW'(MAX_WORDS));
  // rotating instead of shifting restores the original word after a full frame
  assign sh_rot = {sh_q[DATA_W-2:0], sh_q[DATA_W-1]};
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    wd_d = 1'b0;
    sclk_d = sclk_q;
    fsync_d = fsync_q;
    sdata_d = sdata_q;
    buf_d = buf_q;
    sh_d = sh_q;
    left_d = left_q;
    bit_d = bit_q;
    div_d = div_q;
    tmr_d = tmr_q;
`ifdef AD9833_SHADOW_EN
    lw_d = lw_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        buf_d = wr_data >> DATA_W;
        sh_d = wr_data[DATA_W-1:0];
        left_d = num_words - 1'b1;
        err_d = bad_cnt;
        state_d = bad_cnt ? FIN : SETUP;
        done_d = bad_cnt;
        busy_d = !bad_cnt;
        fsync_d = bad_cnt;
        sdata_d = bad_cnt ? 1'b0 : wr_data[DATA_W-1];
        tmr_d = TW'(FSYNC_SETUP-1);
      end
      SETUP: begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == '0) begin
          state_d = SHIFT;
          div_d = DW'(CLK_DIV-1);
          bit_d = BW'(DATA_W-1);
        end
      end
      SHIFT: begin
        div_d = div_q - 1'b1;
        if (div_q == '0) begin
          div_d = DW'(CLK_DIV-1);
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            bit_d = bit_q - 1'b1;
            sh_d = sh_rot;
            sdata_d = (bit_q == '0) ? 1'b0 : sh_q[DATA_W-2];
            if (bit_q == '0) begin
              state_d = GAP;
              fsync_d = 1'b1;
              wd_d = 1'b1;
              tmr_d = TW'(FSYNC_GAP-1);
`ifdef AD9833_SHADOW_EN
              lw_d = sh_rot;
`endif
            end
          end
        end
      end
      GAP: begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == '0) begin
          state_d = (left_q != '0) ? SETUP : FIN;
          done_d = (left_q == '0);
          busy_d = (left_q != '0);
          fsync_d = (left_q == '0);
          sdata_d = (left_q != '0) && buf_q[DATA_W-1];
          sh_d = buf_q[DATA_W-1:0];
          buf_d = buf_q >> DATA_W;
          left_d = left_q - 1'b1;
          tmr_d = TW'(FSYNC_SETUP-1);
        end
      end
      FIN: begin
        state_d = IDLE;
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      wd_q <= 1'b0;
      sclk_q <= 1'b1;
      fsync_q <= 1'b1;
      sdata_q <= 1'b0;
      buf_q <= '0;
      sh_q <= '0;
      left_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      tmr_q <= '0;
`ifdef AD9833_SHADOW_EN
      lw_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      wd_q <= wd_d;
      sclk_q <= sclk_d;
      fsync_q <= fsync_d;
      sdata_q <= sdata_d;
      buf_q <= buf_d;
      sh_q <= sh_d;
      left_q <= left_d;
      bit_q <= bit_d;
      div_q <= div_d;
      tmr_q <= tmr_d;
`ifdef AD9833_SHADOW_EN
      lw_q <= lw_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign word_done = wd_q;
  assign sclk = sclk_q;
  assign fsync = fsync_q;
  assign sdata = sdata_q;
endmodule

// File: tb/tb_ad9833_spi_burst_wr.sv
// tb_ad9833_spi_burst_wr: directed bench for ad9833_spi_burst_wr at default parameters (W = 67 cycles per word).
module tb_ad9833_spi_burst_wr;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] num_words = '0;
  logic [63:0] wr_data = '0;
  logic busy, done, err, word_done, sclk, fsync, sdata;
`ifdef AD9833_SHADOW_EN
  logic [15:0] last_word;
`endif
  int ncmp = 0, nerr = 0, cyc = 0;
  int fs_first, fs_last, done_cyc, nfall, err_at, busy1;
  int wd[$];
  logic [15:0] words[$];
  logic [15:0] lws[$];
  logic [15:0] cap;

  ad9833_spi_burst_wr dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .word_done(word_done),
    .sclk(sclk), .fsync(fsync), .sdata(sdata)
`ifdef AD9833_SHADOW_EN
    , .last_word(last_word)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge sclk) if (!fsync && !rst) begin
    cap = {cap[14:0], sdata};
    nfall++;
  end
  always @(posedge fsync) if (!rst) words.push_back(cap);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [15:0] qw(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 16'hxxxx;
  endfunction

  // start at cycle 0, optional re-start with other data at restart_at, run until done or limit
  task automatic burst(input logic [2:0] nw, input logic [63:0] d, input int restart_at, input int limit);
    wd.delete(); words.delete(); lws.delete();
    fs_first = -1; fs_last = -1; done_cyc = -1; nfall = 0; err_at = -1; busy1 = -1;
    num_words = nw; wr_data = d; start = 1'b1; cyc = 0;
    while (done_cyc < 0 && cyc < limit) begin
      step();
      start = (cyc == restart_at);
      if (cyc == restart_at) wr_data = 64'hABCD_ABCD_ABCD_ABCD;
      if (cyc == 1) busy1 = busy;
      if (!fsync) begin
        if (fs_first < 0) fs_first = cyc;
        fs_last = cyc;
      end
      if (word_done) begin
        wd.push_back(cyc);
`ifdef AD9833_SHADOW_EN
        lws.push_back(last_word);
`endif
      end
      if (done) begin
        done_cyc = cyc;
        err_at = err;
      end
    end
    start = 1'b0;
    step();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int seen;
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wd", word_done, 0);
    chk("rst_sclk", sclk, 1);
    chk("rst_fsync", fsync, 1);
    chk("rst_sdata", sdata, 0);
`ifdef AD9833_SHADOW_EN
    chk("rst_last_word", last_word, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step();

    burst(3'd1, 64'h2100, -1, 200);
    chk("t2_fs_first", fs_first, 1);
    chk("t2_fs_last", fs_last, 65);
    chk("t2_falls", nfall, 16);
    chk("t2_word", qw(words, 0), 16'h2100);
    chk("t2_wd_cyc", qi(wd, 0), 66);
    chk("t2_done_cyc", done_cyc, 68);
    chk("t2_err", err_at, 0);
    chk("t2_busy1", busy1, 1);

    burst(3'd3, {16'h0, 16'h4000, 16'h50C7, 16'h2100}, -1, 400);
    chk("t3_nwd", wd.size(), 3);
    chk("t3_wd0", qi(wd, 0), 66);
    chk("t3_wd1", qi(wd, 1), 133);
    chk("t3_wd2", qi(wd, 2), 200);
    chk("t3_done_cyc", done_cyc, 202);
    chk("t3_falls", nfall, 48);
    chk("t3_word0", qw(words, 0), 16'h2100);
    chk("t3_word1", qw(words, 1), 16'h50C7);
    chk("t3_word2", qw(words, 2), 16'h4000);
    chk("t3_err", err_at, 0);

    burst(3'd0, 64'h1111, -1, 20);
    chk("t4a_done_cyc", done_cyc, 1);
    chk("t4a_err", err_at, 1);
    chk("t4a_fsync", fs_first, -1);
    chk("t4a_falls", nfall, 0);
    burst(3'd5, 64'h2222, -1, 20);
    chk("t4b_done_cyc", done_cyc, 1);
    chk("t4b_err", err_at, 1);
    chk("t4b_fsync", fs_first, -1);

    burst(3'd1, 64'h1234, 20, 200);
    chk("t5_nwords", words.size(), 1);
    chk("t5_word", qw(words, 0), 16'h1234);
    chk("t5_done_cyc", done_cyc, 68);
    chk("t5_falls", nfall, 16);
    chk("t5_err", err_at, 0);

`ifdef AD9833_SHADOW_EN
    burst(3'd2, {32'h0, 16'hC000, 16'h2100}, -1, 300);
    chk("t6_lw0", qw(lws, 0), 16'h2100);
    chk("t6_lw1", qw(lws, 1), 16'hC000);
`endif

    num_words = 3'd2; wr_data = 64'hFFFF_FFFF; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (cyc < 30) step();
    chk("t1_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("t1_sclk", sclk, 1);
    chk("t1_fsync", fsync, 1);
    chk("t1_sdata", sdata, 0);
    chk("t1_busy", busy, 0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done || !fsync) seen++;
    end
    chk("t1_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
